// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency comparator.
// RO_SYNC3_EN selects a three-flop synchroniser instead of two.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COUNT,
    DONE
  } state_t;

  localparam logic [1:0] BYTE_C1_LO = 2'd0;
  localparam logic [1:0] BYTE_C1_HI = 2'd1;
  localparam logic [1:0] BYTE_C2_LO = 2'd2;
  localparam logic [1:0] BYTE_C2_HI = 2'd3;

`ifdef RO_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

endpackage

// File: rtl/ro_edge_counter.sv
// One bank: RO mux, synchroniser, rising-edge detect and
// saturating edge counter with clear and enable.
module ro_edge_counter
  import ro_meas_pkg::*;
#(
  parameter int N_RO  = 32,
  parameter int SEL_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_RO-1:0]  ro,
  input  logic [SEL_W-1:0] sel,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ro[sel]};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;

  // Next value is exported so the parent can compare final counts
  // on the last window cycle, including that cycle's edge.
  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (en && rise && (cnt != {CNT_W{1'b1}}))
      cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/ro_freq_compare.sv
// Compares edge counts of two selected ROs over a gate window.
// Build with RO_SYNC3_EN for a three-flop synchroniser.
module ro_freq_compare
  import ro_meas_pkg::*;
#(
  parameter int N_RO       = 32,
  parameter int SEL_W      = 5,
  parameter int CNT_W      = 16,
  parameter int WIN_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_RO-1:0]  ro1_in,
  input  logic [N_RO-1:0]  ro2_in,
  input  logic [SEL_W-1:0] ro_sel,
  input  logic             start,
  input  logic [1:0]       byte_sel,
  output logic             busy,
  output logic             done,
  output logic             resp,
  output logic [7:0]       dout
);

  localparam int WIN_W = $clog2(WIN_CYCLES + 1);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   sel_q;
  logic [2:0]         st_cnt;
  logic [WIN_W-1:0]   win;
  logic               accept, last, cnt_en;
  logic [CNT_W-1:0]   cnt1, cnt2, cnt1_nxt, cnt2_nxt;
  logic [15:0]        c1x, c2x;
  logic [7:0]         dsel;

  assign cnt_en = (state == COUNT);
  assign busy   = (state == SETTLE) || (state == COUNT);

  ro_edge_counter #(
    .N_RO(N_RO), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) u_bank1 (
    .clk(clk), .rst_n(rst_n), .ro(ro1_in), .sel(sel_q),
    .clr(accept), .en(cnt_en), .cnt(cnt1), .cnt_nxt(cnt1_nxt)
  );

  ro_edge_counter #(
    .N_RO(N_RO), .SEL_W(SEL_W), .CNT_W(CNT_W)
  ) u_bank2 (
    .clk(clk), .rst_n(rst_n), .ro(ro2_in), .sel(sel_q),
    .clr(accept), .en(cnt_en), .cnt(cnt2), .cnt_nxt(cnt2_nxt)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (st_cnt == 3'(SYNC_STAGES))
          state_nxt = COUNT;
      end
      COUNT: begin
        if (win == WIN_W'(WIN_CYCLES - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign c1x = 16'(cnt1);
  assign c2x = 16'(cnt2);

  always_comb begin
    dsel = 8'h00;
    unique case (byte_sel)
      BYTE_C1_LO: dsel = c1x[7:0];
      BYTE_C1_HI: dsel = c1x[15:8];
      BYTE_C2_LO: dsel = c2x[7:0];
      BYTE_C2_HI: dsel = c2x[15:8];
      default:    dsel = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel_q  <= '0;
      st_cnt <= '0;
      win    <= '0;
      resp   <= 1'b0;
      done   <= 1'b0;
      dout   <= '0;
    end else begin
      state <= state_nxt;
      dout  <= dsel;
      if (state == SETTLE) st_cnt <= st_cnt + 1'b1;
      if (state == COUNT)  win    <= win + 1'b1;
      if (accept) begin
        sel_q  <= ro_sel;
        st_cnt <= '0;
        win    <= '0;
        resp   <= 1'b0;
        done   <= 1'b0;
      end
      if (last) begin
        resp <= (cnt1_nxt > cnt2_nxt);
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_compare.sv
// Directed bench: window 64, a 16-bit and a 4-bit counter instance
// fed with clk-synchronous RO waveforms on chosen indices.
module tb_ro_freq_compare;

  localparam int N   = 32;
  localparam int WIN = 64;
`ifdef RO_SYNC3_EN
  localparam int SETTLE = 4;
`else
  localparam int SETTLE = 3;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] ro1_in, ro2_in;
  logic [4:0]   ro_sel;
  logic         start;
  logic [1:0]   byte_sel;
  logic         busy, done, resp;
  logic [7:0]   dout;
  logic         busy_s, done_s, resp_s;
  logic [7:0]   dout_s;

  int total = 0;
  int bad   = 0;
  int ph    = 0;
  int per1  = 0;
  int per2  = 0;
  int idx1  = 0;
  int idx2  = 0;
  int n;

  always #5 clk = ~clk;

  ro_freq_compare #(
    .N_RO(N), .SEL_W(5), .CNT_W(16), .WIN_CYCLES(WIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ro1_in(ro1_in), .ro2_in(ro2_in),
    .ro_sel(ro_sel), .start(start), .byte_sel(byte_sel),
    .busy(busy), .done(done), .resp(resp), .dout(dout)
  );

  ro_freq_compare #(
    .N_RO(N), .SEL_W(5), .CNT_W(4), .WIN_CYCLES(WIN)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .ro1_in(ro1_in), .ro2_in(ro2_in),
    .ro_sel(ro_sel), .start(start), .byte_sel(byte_sel),
    .busy(busy_s), .done(done_s), .resp(resp_s), .dout(dout_s)
  );

  function automatic logic wave(input int p, input int t);
    return (p > 0) && ((t % p) < (p / 2));
  endfunction

  // Selected index gets its period; every other index runs at period 4
  always @(negedge clk) begin
    ph = ph + 1;
    for (int i = 0; i < N; i++) begin
      ro1_in[i] = wave((i == idx1) ? per1 : 4, ph);
      ro2_in[i] = wave((i == idx2) ? per2 : 4, ph);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] b);
    byte_sel = b;
    tick;
  endtask

  task automatic launch(input logic [4:0] s);
    ro_sel = s;
    start  = 1'b1;
    tick;
    start  = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("done_clr_start", done, 0);
  endtask

  task automatic wait_done(output int cyc, input int already);
    cyc = already;
    while (!done && cyc < 400) begin
      tick;
      cyc++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    ro_sel   = '0;
    start    = 1'b0;
    byte_sel = 2'd0;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_resp", resp, 0);
    chk("rst_dout", dout, 8'h00);
    rst_n = 1'b1;
    tick;

    // basic: period 8 vs 16 on index 3
    per1 = 8; per2 = 16; idx1 = 3; idx2 = 3;
    launch(5'd3);
    wait_done(n, 0);
    chk("basic_cycles", n, SETTLE + WIN);
    chk("basic_busy_off", busy, 0);
    chk("basic_resp", resp, 1);
    rd(2'd0); chk("basic_c1_lo", dout, 8'h08);
    rd(2'd1); chk("basic_c1_hi", dout, 8'h00);
    rd(2'd2); chk("basic_c2_lo", dout, 8'h04);
    rd(2'd3); chk("basic_c2_hi", dout, 8'h00);
    chk("basic_done_hold", done, 1);

    // tie on index 7
    per1 = 8; per2 = 8; idx1 = 7; idx2 = 7;
    launch(5'd7);
    wait_done(n, 0);
    chk("tie_cycles", n, SETTLE + WIN);
    chk("tie_resp", resp, 0);
    rd(2'd0); chk("tie_c1_lo", dout, 8'h08);
    rd(2'd2); chk("tie_c2_lo", dout, 8'h08);

    // saturation: period 2 -> 32 edges, 4-bit instance clamps at 15
    per1 = 2; per2 = 8; idx1 = 3; idx2 = 3;
    launch(5'd3);
    wait_done(n, 0);
    chk("sat_done_s", done_s, 1);
    chk("sat_resp_s", resp_s, 1);
    rd(2'd0);
    chk("sat_c1_lo_s", dout_s, 8'h0F);
    chk("sat_c1_lo_wide", dout, 8'h20);
    rd(2'd1);
    chk("sat_c1_hi_s", dout_s, 8'h00);
    rd(2'd2);
    chk("sat_c2_lo_s", dout_s, 8'h08);

    // start and ro_sel change during COUNT are ignored
    per1 = 8; per2 = 16; idx1 = 3; idx2 = 3;
    launch(5'd3);
    for (int i = 0; i < SETTLE + 10; i++) tick;
    ro_sel = 5'd9;
    start  = 1'b1;
    tick;
    start  = 1'b0;
    chk("ign_busy", busy, 1);
    wait_done(n, SETTLE + 11);
    chk("ign_cycles", n, SETTLE + WIN);
    chk("ign_resp", resp, 1);
    rd(2'd0); chk("ign_c1_lo", dout, 8'h08);
    rd(2'd2); chk("ign_c2_lo", dout, 8'h04);

    // reset at COUNT cycle 20 aborts the measurement
    launch(5'd3);
    for (int i = 0; i < SETTLE + 20; i++) tick;
    byte_sel = 2'd0;
    rst_n    = 1'b0;
    tick;
    rst_n    = 1'b1;
    chk("rstm_busy", busy, 0);
    chk("rstm_done", done, 0);
    chk("rstm_dout", dout, 8'h00);
    tick;
    chk("rstm_cnt1", dout, 8'h00);
    chk("rstm_idle", busy, 0);
    rd(2'd2); chk("rstm_cnt2", dout, 8'h00);
    launch(5'd3);
    wait_done(n, 0);
    chk("rstm_cycles", n, SETTLE + WIN);
    chk("rstm_resp", resp, 1);
    rd(2'd0); chk("rstm_c1_lo", dout, 8'h08);
    rd(2'd2); chk("rstm_c2_lo", dout, 8'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ro_freq_compare.md
Name: ro_freq_compare

Overview:
- Measurement stage directly downstream of the ring-oscillator bank; consumes its two 32-bit RO output buses.
- Selects one oscillator from each bank and synchronises both into the clk domain.
- Counts rising edges of each over a fixed gate window and produces a comparison response bit (PUF-style).
- Counts are exposed byte-wise so the top level can drive its 8-bit output port.

Parameters:
- N_RO, 32, oscillators per bank.
- SEL_W, 5, width of the RO index (clog2 of N_RO).
- CNT_W, 16, edge-counter width; counters saturate.
- WIN_CYCLES, 1024, gate window length in clk cycles; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- ro1_in  in  N_RO  bank-1 oscillator outputs, asynchronous.
- ro2_in  in  N_RO  bank-2 oscillator outputs, asynchronous.
- ro_sel  in  SEL_W  index of the RO compared in each bank; sampled on accepted start.
- start  in  1  begin measurement; single-cycle pulse or level.
- byte_sel  in  2  output byte select: 0=cnt1[7:0], 1=cnt1[15:8], 2=cnt2[7:0], 3=cnt2[15:8].
- busy  out  1  high in SETTLE and COUNT.
- done  out  1  high in DONE until the next accepted start.
- resp  out  1  1 iff cnt1 > cnt2; valid while done.
- dout  out  8  registered byte selected by byte_sel.

Behaviour:
- Reset: rst_n low at a clk edge forces IDLE, cnt1=cnt2=0, busy=0, done=0, resp=0, dout=0, and clears synchroniser and edge registers. Reset applies mid-measurement too; the measurement is aborted.
- FSM, IDLE -> SETTLE: start=1 in IDLE or DONE. Latch ro_sel, clear cnt1, cnt2, resp and done.
- start is ignored while busy.
- SETTLE lasts SYNC_STAGES+1 cycles so the synchroniser and previous-sample registers hold valid data; no counting. Then -> COUNT.
- COUNT lasts exactly WIN_CYCLES cycles. Each cycle, for each bank:
  - rising edge = sync_q & ~prev_q;
  - on an edge, the counter increments, saturating at 2^CNT_W-1.
- On the last COUNT cycle, the edge for that cycle is included. Next state is DONE; resp is registered as cnt1_final > cnt2_final.
- Tie gives resp=0.
- DONE: hold counts, resp and done=1. A start here restarts as above.
- dout <= the selected byte every cycle; 1-cycle latency from byte_sel or count change. dout is valid in any state.
- ro_sel changes after start have no effect until the next start.
- Edges are sampled at clk rate: RO toggling faster than clk/2 aliases. Prescaling belongs upstream; this block does no prescaling.
- Window counter width is clog2(WIN_CYCLES+1).

Optional Feature:
- RO_SYNC3_EN defined: SYNC_STAGES=3, giving a three-flop synchroniser per bank and a SETTLE length of 4 cycles.
- Undefined: SYNC_STAGES=2, giving a two-flop synchroniser and a SETTLE length of 3 cycles.
- Counting, window and resp semantics are identical in both cases; only latency from start to done differs by 1 cycle.

Decomposition:
- Package ro_meas_pkg holds:
  - state enum {IDLE, SETTLE, COUNT, DONE};
  - byte_sel encodings BYTE_C1_LO, BYTE_C1_HI, BYTE_C2_LO, BYTE_C2_HI;
  - SYNC_STAGES, derived from RO_SYNC3_EN.
- Sub-module ro_edge_counter (RO mux, synchroniser, edge detect, saturating counter with clear/enable), instantiated twice.
- FSM, window counter, resp and dout mux live in the parent.

Test Plan:
- Basic comparison, WIN_CYCLES=64, ro_sel=3: ro1_in[3] period 8 clk, ro2_in[3] period 16 clk, pulse start. Required: busy for SETTLE+64 cycles, then done=1, cnt1=8, cnt2=4, resp=1; byte_sel=0 gives dout=0x08 one cycle later, byte_sel=2 gives 0x04.
- Tie: both banks ro_sel=7 with identical period 8. Required: cnt1=cnt2=8, resp=0.
- Saturation, CNT_W=4: ro1 period 2 clk over 64 cycles (32 edges). Required: cnt1=15; byte_sel=1 gives dout=0x00.
- Start ignored while busy; ro_sel changed mid-COUNT: start pulsed again in COUNT and ro_sel changed. Required: no restart, counts reflect the original index, done at the original cycle.
- Reset mid-COUNT: rst_n low 1 cycle at COUNT cycle 20. Required: next cycle IDLE, busy=0, done=0, dout=0, counts 0; a fresh start then completes normally.
- Macro check: run the basic test with and without RO_SYNC3_EN. Required: done rises at start+1+4+64 vs start+1+3+64 cycles; counts identical.
